// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

    // A port competes only while requesting and not in its own completion cycle.
    function automatic logic port_eligible(input logic req, input logic done);
        return req & ~done;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_fair.sv
// Data-first priority with a bounded streak so a waiting fetch is not starved.
module mem_port_arbiter_fair #(
    parameter int MAX_STREAK = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic elig_i,
    input  logic elig_d,
    input  logic if_req,
    output logic gnt_i,
    output logic gnt_d
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak_q;
    logic          streak_lt;

    assign streak_lt = (streak_q < SW'(MAX_STREAK));
    assign gnt_d     = arb_en & elig_d & (streak_lt | ~elig_i);
    assign gnt_i     = arb_en & elig_i & ~gnt_d;

    // Streak counts data grants made while a fetch request is pending, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else if (gnt_d) begin
            if (!if_req) begin
                streak_q <= '0;
            end else if (streak_lt) begin
                streak_q <= streak_q + SW'(1);
            end
        end else if (gnt_i) begin
            streak_q <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch port and the load/store port.
//
// state     | meaning
// ST_IDLE   | no access in flight; arbitrate eligible requests this cycle
// ST_BUSY_I | fetch read in flight, strobes driven for LAT cycles
// ST_BUSY_D | load or store in flight, strobes driven for LAT cycles
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int LAT        = 2,
    parameter int MAX_STREAK = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_done,
    output logic          stall_if,
    output logic          stall_d,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic          cnt_zero;
    logic          arb_en;
    logic          finish;
    logic          elig_i;
    logic          elig_d;
    logic          gnt_i;
    logic          gnt_d;

    logic [AW-1:0] mem_addr_q;
    logic          mem_rd_q;
    logic          mem_wr_q;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          if_done_q;
    logic          d_done_q;

    assign cnt_zero = (cnt_q == '0);
    assign elig_i   = port_eligible(if_req, if_done_q);
    assign elig_d   = port_eligible(d_req, d_done_q);

    mem_port_arbiter_fair #(
        .MAX_STREAK(MAX_STREAK)
    ) u_fair (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_en (arb_en),
        .elig_i (elig_i),
        .elig_d (elig_d),
        .if_req (if_req),
        .gnt_i  (gnt_i),
        .gnt_d  (gnt_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_d) begin
                    state_d = ST_BUSY_D;
                end else if (gnt_i) begin
                    state_d = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        arb_en = 1'b0;
        finish = 1'b0;
        case (state_q)
            ST_IDLE:              arb_en = 1'b1;
            ST_BUSY_I, ST_BUSY_D: finish = cnt_zero;
            default:              arb_en = 1'b0;
        endcase
    end

    // Strobes and latched operands are registered so the memory sees clean levels for all LAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            if (gnt_d) begin
                cnt_q       <= CW'(LAT - 1);
                mem_addr_q  <= d_addr;
                mem_rd_q    <= ~d_we;
                mem_wr_q    <= d_we;
                mem_wdata_q <= d_we ? d_wdata : '0;
            end else if (gnt_i) begin
                cnt_q       <= CW'(LAT - 1);
                mem_addr_q  <= if_addr;
                mem_rd_q    <= 1'b1;
                mem_wr_q    <= 1'b0;
                mem_wdata_q <= '0;
            end else if (finish) begin
                mem_addr_q  <= '0;
                mem_rd_q    <= 1'b0;
                mem_wr_q    <= 1'b0;
                mem_wdata_q <= '0;
                if (state_q == ST_BUSY_I) begin
                    if_done_q  <= 1'b1;
                    if_rdata_q <= mem_rdata;
                end else begin
                    d_done_q <= 1'b1;
                    if (mem_rd_q) begin
                        d_rdata_q <= mem_rdata;
                    end
                end
            end else if (!arb_en) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_d   = d_req & ~d_done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a cycle-level behavioural model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int LAT  = 2;
    localparam int MAXS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_done;
    logic          stall_if;
    logic          stall_d;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    mem_port_arbiter #(.AW(AW), .LAT(LAT), .MAX_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .stall_if(stall_if), .stall_d(stall_d),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: one outstanding access with a remaining-cycle count.
    int          acc_left;
    bit          acc_d, acc_we;
    logic [31:0] acc_addr, acc_wdata;
    bit          m_if_done, m_d_done;
    logic [31:0] m_if_rdata, m_d_rdata;
    int          m_streak;
    bit          if_prev_done, d_prev_done;
    int          cnt_if_done_obs, cnt_d_done_obs;
    bit          last_if_done_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        acc_left = 0; acc_d = 0; acc_we = 0; acc_addr = '0; acc_wdata = '0;
        m_if_done = 0; m_d_done = 0; m_if_rdata = '0; m_d_rdata = '0; m_streak = 0;
    endtask

    task automatic model_step();
        bit nid, ndd, ei, ed;
        nid = 0; ndd = 0;
        if (acc_left > 0) begin
            acc_left--;
            if (acc_left == 0) begin
                if (!acc_we) begin
                    if (acc_d) m_d_rdata = mem_rdata;
                    else       m_if_rdata = mem_rdata;
                end
                if (acc_d) ndd = 1;
                else       nid = 1;
            end
        end else begin
            ei = if_req && !m_if_done;
            ed = d_req && !m_d_done;
            if (ed && (m_streak < MAXS || !ei)) begin
                acc_left = LAT; acc_d = 1; acc_we = d_we; acc_addr = d_addr;
                acc_wdata = d_we ? d_wdata : 32'h0;
                m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else if (ei) begin
                acc_left = LAT; acc_d = 0; acc_we = 0; acc_addr = if_addr; acc_wdata = '0;
                m_streak = 0;
            end
        end
        m_if_done = nid;
        m_d_done  = ndd;
    endtask

    task automatic check_outputs();
        bit busy;
        busy = (acc_left > 0);
        chk("if_done",   32'(if_done),   32'(m_if_done));
        chk("d_done",    32'(d_done),    32'(m_d_done));
        chk("if_rdata",  if_rdata,       m_if_rdata);
        chk("d_rdata",   d_rdata,        m_d_rdata);
        chk("stall_if",  32'(stall_if),  32'(if_req && !m_if_done));
        chk("stall_d",   32'(stall_d),   32'(d_req && !m_d_done));
        chk("mem_rd",    32'(mem_rd),    32'(busy && !acc_we));
        chk("mem_wr",    32'(mem_wr),    32'(busy && acc_we));
        chk("mem_addr",  mem_addr,       busy ? acc_addr : 32'h0);
        chk("mem_wdata", mem_wdata,      busy ? acc_wdata : 32'h0);
    endtask

    // Called at a falling edge with this cycle's inputs already applied.
    task automatic cycle();
        #1;
        check_outputs();
        last_if_done_obs = if_done;
        if (if_done) cnt_if_done_obs++;
        if (d_done)  cnt_d_done_obs++;
        if_prev_done = m_if_done;
        d_prev_done  = m_d_done;
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        if_req = 0; d_req = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; mem_rdata = '0;
        model_reset();
        if_prev_done = 0; d_prev_done = 0;
        cnt_if_done_obs = 0; cnt_d_done_obs = 0; last_if_done_obs = 0;
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1;

        // Fetch of 0x40
        if_req = 1; if_addr = 32'h40; mem_rdata = 32'hDEADBEEF;
        cycle();
        #1; chk("t1_mem_rd_c1", 32'(mem_rd), 1); chk("t1_addr_c1", mem_addr, 32'h40);
        cycle(); cycle();
        #1; chk("t1_if_done_c3", 32'(if_done), 1); chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        cycle();
        idle_cycles(2);

        // Simultaneous fetch and load: data first, fetch granted in the data done cycle
        if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
        mem_rdata = 32'hA5A50001;
        cycle(); cycle(); cycle();
        #1; chk("t2_d_done_c3", 32'(d_done), 1); chk("t2_d_rdata", d_rdata, 32'hA5A50001);
        chk("t2_mem_rd_c3", 32'(mem_rd), 0);
        cycle();
        d_req = 0; mem_rdata = 32'h0BAD0002;
        #1; chk("t2_i_addr_c4", mem_addr, 32'h100);
        cycle(); cycle();
        #1; chk("t2_if_done_c6", 32'(if_done), 1); chk("t2_if_rdata", if_rdata, 32'h0BAD0002);
        cycle();
        idle_cycles(2);

        // Store, request dropped mid-access; load data register must be untouched
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h1234; mem_rdata = 32'hFFFF0000;
        cycle();
        d_req = 0; d_wdata = 32'h9999;
        #1; chk("t4_mem_wr_c1", 32'(mem_wr), 1); chk("t4_wdata_c1", mem_wdata, 32'h1234);
        cycle(); cycle();
        #1; chk("t4_d_done_c3", 32'(d_done), 1); chk("t4_d_rdata_kept", d_rdata, 32'hA5A50001);
        cycle();
        idle_cycles(2);

        // Both requests held continuously: grants alternate since a done cycle excludes its owner
        cnt_if_done_obs = 0; cnt_d_done_obs = 0;
        if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400;
        for (int i = 0; i < 19; i++) begin
            mem_rdata = $urandom;
            cycle();
        end
        chk("t3_d_done_count", 32'(cnt_d_done_obs), 3);
        chk("t3_if_done_count", 32'(cnt_if_done_obs), 3);
        idle_cycles(6);

        // Fetch held through its done cycle: a single access and a single done
        cnt_if_done_obs = 0;
        if_req = 1; if_addr = 32'h80; mem_rdata = 32'h55AA55AA;
        for (int i = 0; i < 4; i++) cycle();
        idle_cycles(6);
        chk("t6_single_done", 32'(cnt_if_done_obs), 1);

        // Reset during the first access cycle
        if_req = 1; if_addr = 32'hC0; mem_rdata = 32'h13572468;
        cycle();
        rst_n = 0;
        model_reset();
        #1; chk("t5_mem_rd_rst", 32'(mem_rd), 0); chk("t5_addr_rst", mem_addr, 32'h0);
        chk("t5_if_rdata_rst", if_rdata, 32'h0);
        cycle(); cycle();
        rst_n = 1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!last_if_done_obs && k < 10);
        chk("t5_done_latency", 32'(k), 32'(LAT + 2));
        idle_cycles(3);

        // Random traffic from two protocol-following requesters
        if_prev_done = 0; d_prev_done = 0;
        for (int i = 0; i < 400; i++) begin
            mem_rdata = $urandom;
            if (if_req) begin
                if (if_prev_done) begin
                    if_req  = 1'($urandom_range(0, 1));
                    if_addr = $urandom & 32'hFFFF_FFFC;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req  = 1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (d_req) begin
                if (d_prev_done) begin
                    d_req   = 1'($urandom_range(0, 1));
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                d_req   = 1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            cycle();
        end
        idle_cycles(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
